// File: rtl/mem_port_arbiter_pkg.sv
// Shared RV32I types plus the memory-port arbiter state and grant encodings.
// Build option MEM_ARB_RR_EN selects round-robin tie breaking in mem_arb_pick.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } mem_arb_state_t;

  localparam logic MEM_ARB_GRANT_D = 1'b1;
  localparam logic MEM_ARB_GRANT_I = 1'b0;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and downstream memory port signals of the arbiter.
// slave: arbiter view; master: core and memory side view.
interface mem_arb_if;
  import rv32i_types::*;

  logic           i_read;
  rv32i_word      i_address;
  logic           i_resp;
  rv32i_word      i_rdata;

  logic           d_read;
  logic           d_write;
  rv32i_word      d_address;
  rv32i_word      d_wdata;
  rv32i_mem_wmask d_byte_enable;
  logic           d_resp;
  rv32i_word      d_rdata;

  logic           mem_read;
  logic           mem_write;
  rv32i_word      mem_address;
  rv32i_word      mem_wdata;
  rv32i_mem_wmask mem_byte_enable;
  logic           mem_resp;
  rv32i_word      mem_rdata;

  modport slave (
    input  i_read, i_address,
    output i_resp, i_rdata,
    input  d_read, d_write, d_address,
    input  d_wdata, d_byte_enable,
    output d_resp, d_rdata,
    output mem_read, mem_write, mem_address,
    output mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata
  );

  modport master (
    output i_read, i_address,
    input  i_resp, i_rdata,
    output d_read, d_write, d_address,
    output d_wdata, d_byte_enable,
    input  d_resp, d_rdata,
    input  mem_read, mem_write, mem_address,
    input  mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection for the memory-port arbiter.
// MEM_ARB_RR_EN: ties go to the requester not served last; else data wins.
module mem_arb_pick
  import rv32i_types::*;
(
  input  logic           i_req,
  input  logic           d_req,
  input  logic           last_grant,
  output mem_arb_state_t grant
);

  logic tie_to_d;

`ifdef MEM_ARB_RR_EN
  assign tie_to_d = (last_grant != MEM_ARB_GRANT_D);
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign tie_to_d = 1'b1;
`endif

  always_comb begin
    grant = IDLE;
    unique case (1'b1)
      (i_req && d_req):  grant = tie_to_d ? GRANT_D : GRANT_I;
      (d_req && !i_req): grant = GRANT_D;
      (i_req && !d_req): grant = GRANT_I;
      default:           grant = IDLE;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes fetch and data requesters onto one memory port.
// Tie policy is set by MEM_ARB_RR_EN inside mem_arb_pick.
module mem_port_arbiter
  import rv32i_types::*;
(
  input logic     clk,
  input logic     rst,
  mem_arb_if.slave bus
);

  mem_arb_state_t state;
  mem_arb_state_t pick;
  logic           last_grant;
  logic           i_req;
  logic           d_req;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  // A response always wins over a same-cycle request drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= MEM_ARB_GRANT_D;
    end else begin
      unique case (state)
        IDLE: state <= pick;
        GRANT_I: begin
          if (bus.mem_resp) begin
            state      <= IDLE;
            last_grant <= MEM_ARB_GRANT_I;
          end else if (!i_req) begin
            state <= IDLE;
          end
        end
        GRANT_D: begin
          if (bus.mem_resp) begin
            state      <= IDLE;
            last_grant <= MEM_ARB_GRANT_D;
          end else if (!d_req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;
    bus.i_resp          = 1'b0;
    bus.d_resp          = 1'b0;
    bus.i_rdata         = '0;
    bus.d_rdata         = '0;
    unique case (state)
      GRANT_I: begin
        bus.mem_read        = bus.i_read;
        bus.mem_address     = bus.i_address;
        bus.mem_byte_enable = 4'hF;
        bus.i_resp          = bus.mem_resp;
        bus.i_rdata         = bus.mem_rdata;
        bus.d_rdata         = bus.mem_rdata;
      end
      GRANT_D: begin
        bus.mem_read        = bus.d_read;
        bus.mem_write       = bus.d_write;
        bus.mem_address     = bus.d_address;
        bus.mem_wdata       = bus.d_wdata;
        bus.mem_byte_enable = bus.d_byte_enable;
        bus.d_resp          = bus.mem_resp;
        bus.i_rdata         = bus.mem_rdata;
        bus.d_rdata         = bus.mem_rdata;
      end
      default: ;
    endcase
  end

endmodule
